// File: rtl/mcbc_pkg.sv
// Shared types and width helpers for the multi-channel buffer controller.
package mcbc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } buf_state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_buffer_ctrl_if.sv
// Write-channel and merged-output handshake bundle.
interface multi_channel_buffer_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int CHW    = 2
);

  logic [NUM_CH-1:0]        wr_valid;
  logic [NUM_CH-1:0]        wr_ready;
  logic [NUM_CH*DATA_W-1:0] wr_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CHW-1:0]           out_ch;

  modport master (
    output wr_valid, wr_data, out_ready,
    input  wr_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  wr_valid, wr_data, out_ready,
    output wr_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/mcbc_channel_fifo.sv
// Single-channel circular FIFO with occupancy count and status flags.
module mcbc_channel_fifo #(
  parameter int DEPTH    = 64,
  parameter int DATA_W   = 32,
  parameter int AF_LEVEL = 60,
  parameter int CW       = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o
);

  localparam int PW = CW - 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign afull_o = (cnt_q >= CW'(AF_LEVEL));

endmodule

// File: rtl/multi_channel_buffer_ctrl.sv
// Per-channel FIFOs merged by a round-robin arbiter into one output register.
// Define MCBC_STATS_EN to build the saturating performance counters.
module multi_channel_buffer_ctrl
  import mcbc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 64,
  parameter int DATA_W   = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  localparam int CW      = cnt_w(DEPTH),
  localparam int CHW     = ch_w(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  multi_channel_buffer_ctrl_if.slave bus,
  output logic [NUM_CH-1:0]    ch_full,
  output logic [NUM_CH-1:0]    ch_empty,
  output logic [NUM_CH-1:0]    ch_afull,
  output logic [NUM_CH*CW-1:0] ch_count,
  output logic [1:0]           state,
  output logic [31:0]          stat_wr,
  output logic [31:0]          stat_rd,
  output logic [31:0]          stat_stall
);

  buf_state_t        state_q, state_d;
  logic [NUM_CH-1:0] push, pop;
  logic [DATA_W-1:0] fifo_data [NUM_CH];
  logic [CHW-1:0]    grant, rr_q, rr_d;
  logic              found, pop_en, do_pop;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CHW-1:0]    out_ch_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mcbc_channel_fifo #(
      .DEPTH    (DEPTH),
      .DATA_W   (DATA_W),
      .AF_LEVEL (AF_LEVEL),
      .CW       (CW)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .data_i  (bus.wr_data[c*DATA_W +: DATA_W]),
      .data_o  (fifo_data[c]),
      .count_o (ch_count[c*CW +: CW]),
      .full_o  (ch_full[c]),
      .empty_o (ch_empty[c]),
      .afull_o (ch_afull[c])
    );
  end

  // Full is the registered flag, so a same-cycle pop never frees a slot.
  assign bus.wr_ready = {NUM_CH{state_q == RUN}} & ~ch_full;
  assign push         = bus.wr_valid & bus.wr_ready;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && !ch_empty[idx]) begin
        found = 1'b1;
        grant = CHW'(idx);
      end
    end
  end

  assign pop_en = ((state_q == RUN) || (state_q == DRAIN))
                  && (!out_valid_q || bus.out_ready);
  assign do_pop = pop_en && found;

  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = do_pop && (grant == CHW'(c));
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (do_pop) begin
      rr_d = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) state_d = RUN;
        else if (&ch_empty && !out_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (do_pop) begin
        out_valid_q <= 1'b1;
        out_data_q  <= fifo_data[grant];
        out_ch_q    <= grant;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign state         = state_q;

`ifdef MCBC_STATS_EN
  logic [31:0] wr_q, rd_q, stall_q;
  logic [32:0] wr_sum;

  always_comb begin
    wr_sum = {1'b0, wr_q};
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sum = wr_sum + 33'(push[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else begin
      wr_q <= wr_sum[32] ? '1 : wr_sum[31:0];
      if (out_valid_q && bus.out_ready && rd_q != '1)
        rd_q <= rd_q + 32'd1;
      if (|(bus.wr_valid & ~bus.wr_ready) && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_wr    = wr_q;
  assign stat_rd    = rd_q;
  assign stat_stall = stall_q;
`else
  assign stat_wr    = '0;
  assign stat_rd    = '0;
  assign stat_stall = '0;
`endif

endmodule
